sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
- Serial-to-parallel stage placed directly downstream of the single-bit D flip-flop register stage.
- Takes the registered serial bit stream (one bit per qualified clock) and assembles it into WIDTH-bit words.
- Presents each completed word on a one-entry valid/ready output register.
- Provides frame re-alignment via `sync` and a sticky overrun flag for words lost to back-pressure.

Parameters:
- WIDTH, 8, word length in bits; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0].

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset; asserts immediately, deasserts synchronously to clk.
- din  input  1  serial data bit (the registered q of the upstream flip-flop stage).
- din_valid  input  1  din is a valid bit this cycle; bits are never refused.
- sync  input  1  frame start; restarts word alignment.
- dout  output  WIDTH  assembled word (output register).
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle.
- bit_cnt  output  CW  bits collected into the current partial word; CW = clog2(WIDTH).
- overrun  output  1  sticky: a completed word was dropped.
- overrun_clr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst_n=0, async):
  - shift register, bit_cnt, dout, dout_valid and overrun all go to 0.
  - Any partial word is discarded.
  - Reset is legal mid-word and mid-handshake.
- Bit accept: every cycle with din_valid=1 accepts din; there is no input back-pressure.
- Shift rule:
  - MSB_FIRST=1: shreg <= {shreg[WIDTH-2:0], din}.
  - MSB_FIRST=0: shreg <= {din, shreg[WIDTH-1:1]}.
- bit_cnt:
  - Increments per accepted bit, range 0..WIDTH-1.
  - Wraps to 0 on the WIDTH-th bit.
  - Holds when din_valid=0.
- sync=1:
  - Partial word discarded.
  - If din_valid=1 the same cycle, that bit becomes bit 0 of a new word (bit_cnt <= 1).
  - Otherwise bit_cnt <= 0.
  - sync never touches dout, dout_valid or overrun.
- Word completion: an accepted bit while bit_cnt==WIDTH-1 (and sync=0). The completed word includes that bit.
- Load rule: the completed word loads into dout if `!dout_valid || dout_ready`, with dout_valid <= 1. Latency: dout/dout_valid update on the clock edge after the final bit's cycle.
- Drain: a handshake (dout_valid && dout_ready) with no simultaneous load gives dout_valid <= 0. dout holds its last value.
- Simultaneous drain + completion:
  - The old word is consumed and the new word loads.
  - dout_valid stays 1; no overrun.
- Overrun: completion while dout_valid=1 and dout_ready=0:
  - New word dropped; dout unchanged; overrun <= 1.
  - bit_cnt still wraps to 0.
- overrun_clr: clears overrun next edge. Set wins over clear in the same cycle.
- Output stability: dout is stable while dout_valid=1 && dout_ready=0.
- Outputs are registered only; no combinational path from inputs to outputs.

Test Plan:
- Reset, then WIDTH=8, MSB_FIRST=1, din_valid=1 every cycle, dout_ready=1, bits 1,0,1,0,0,1,0,1 -> dout=0xA5, dout_valid high for exactly 1 cycle starting the edge after bit 8, bit_cnt back to 0.
- MSB_FIRST=0, bits 1,0,1,1,0,0,0,1 with din_valid toggling 1/0 between bits -> bit_cnt holds on idle cycles; dout=0x8D.
- dout_ready=0, send 0x11 then 0x22 (MSB-first) -> dout stays 0x11, overrun=1 after bit 16; then dout_ready=1 for one cycle -> dout_valid=0; overrun_clr -> overrun=0. Also pulse overrun_clr on the same cycle as a new overrun -> overrun stays 1.
- dout_ready=0 holding 0x11; raise dout_ready in the cycle of the final bit of 0x22 -> no overrun, dout=0x22, dout_valid continuously 1.
- Send 3 junk bits, then sync=1 with the first bit of 0xC3 -> dout=0xC3 after 8 more accepted bits; the junk bits never appear in dout.
- Assert rst_n=0 asynchronously (between edges) after 5 bits with dout_valid=1 -> all outputs 0 immediately; after release, a full 0x5A word is received correctly.

Source files
------------

// File: rtl/sipo_deserializer_if.sv
// Serial-in / word-out bundle between the bit source, the deserializer and the word consumer.
interface sipo_deserializer_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             din;
  logic             din_valid;
  logic             sync;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [CW-1:0]    bit_cnt;
  logic             overrun;
  logic             overrun_clr;

  modport master (
    output din, din_valid, sync, dout_ready, overrun_clr,
    input  dout, dout_valid, bit_cnt, overrun
  );

  modport slave (
    input  din, din_valid, sync, dout_ready, overrun_clr,
    output dout, dout_valid, bit_cnt, overrun
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Assembles a registered serial bit stream into WIDTH-bit words behind a one-entry
// valid/ready output register, with sync re-alignment and a sticky overrun flag.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sipo_deserializer_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic [WIDTH-1:0] dout_q,  dout_d;
  logic             vld_q,   vld_d;
  logic             ovr_q,   ovr_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] first_bit;
  logic             complete;

  always_comb begin
    if (MSB_FIRST) begin
      shifted   = {shreg_q[WIDTH-2:0], bus.din};
      first_bit = {{(WIDTH-1){1'b0}}, bus.din};
    end else begin
      shifted   = {bus.din, shreg_q[WIDTH-1:1]};
      first_bit = {bus.din, {(WIDTH-1){1'b0}}};
    end
  end

  assign complete = bus.din_valid && !bus.sync && (cnt_q == LAST);

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    ovr_d   = ovr_q;

    // sync drops the partial word; a bit arriving with it starts the new word
    if (bus.sync) begin
      shreg_d = bus.din_valid ? first_bit : '0;
      cnt_d   = bus.din_valid ? CW'(1) : '0;
    end else if (bus.din_valid) begin
      shreg_d = shifted;
      cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    if (bus.overrun_clr) ovr_d = 1'b0;

    if (complete) begin
      if (!vld_q || bus.dout_ready) begin
        dout_d = shifted;
        vld_d  = 1'b1;
      end else begin
        ovr_d  = 1'b1;
      end
    end else if (vld_q && bus.dout_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q;
  assign bus.bit_cnt    = cnt_q;
  assign bus.overrun    = ovr_q;
endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench: one MSB-first and one LSB-first deserializer sharing clock and reset.
module tb_sipo_deserializer;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sipo_deserializer_if #(.WIDTH(8)) ifa ();
  sipo_deserializer_if #(.WIDTH(8)) ifb ();

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Sends v[hi] down to v[lo] on port A, one bit per cycle
  task automatic send_a(input logic [7:0] v, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      ifa.din       = v[i];
      ifa.din_valid = 1'b1;
      cyc();
    end
  endtask

  task automatic idle_a();
    ifa.din_valid = 1'b0;
    cyc();
  endtask

  task automatic send_b(input logic b);
    ifb.din       = b;
    ifb.din_valid = 1'b1;
    cyc();
  endtask

  task automatic idle_b();
    ifb.din_valid = 1'b0;
    cyc();
  endtask

  initial begin
    logic [7:0] lsb_bits;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    ifa.din = 1'b0; ifa.din_valid = 1'b0; ifa.sync = 1'b0; ifa.dout_ready = 1'b0; ifa.overrun_clr = 1'b0;
    ifb.din = 1'b0; ifb.din_valid = 1'b0; ifb.sync = 1'b0; ifb.dout_ready = 1'b0; ifb.overrun_clr = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_dout",  32'(ifa.dout),       32'h0);
    chk("rst_a_valid", 32'(ifa.dout_valid), 32'h0);
    chk("rst_a_cnt",   32'(ifa.bit_cnt),    32'h0);
    chk("rst_a_ovr",   32'(ifa.overrun),    32'h0);
    chk("rst_b_valid", 32'(ifb.dout_valid), 32'h0);
    rst_n = 1'b1;
    cyc();

    // MSB-first 0xA5, continuous bits, consumer always ready
    ifa.dout_ready = 1'b1;
    send_a(8'hA5, 7, 5);
    chk("t1_cnt3",    32'(ifa.bit_cnt),    32'd3);
    chk("t1_nvalid",  32'(ifa.dout_valid), 32'h0);
    send_a(8'hA5, 4, 0);
    chk("t1_dout",    32'(ifa.dout),       32'hA5);
    chk("t1_valid",   32'(ifa.dout_valid), 32'h1);
    chk("t1_cnt0",    32'(ifa.bit_cnt),    32'd0);
    idle_a();
    chk("t1_drained", 32'(ifa.dout_valid), 32'h0);
    chk("t1_hold",    32'(ifa.dout),       32'hA5);

    // LSB-first 0x8D with idle cycles between bits
    ifb.dout_ready = 1'b1;
    lsb_bits = 8'b1011_0001;   // arrival order: 1,0,1,1,0,0,0,1
    for (int i = 7; i >= 0; i--) begin
      send_b(lsb_bits[i]);
      if (i != 0) begin
        idle_b();
        chk("t2_cnt_hold", 32'(ifb.bit_cnt), 32'(8 - i));
      end
    end
    chk("t2_dout",  32'(ifb.dout),       32'h8D);
    chk("t2_valid", 32'(ifb.dout_valid), 32'h1);
    chk("t2_cnt0",  32'(ifb.bit_cnt),    32'd0);
    idle_b();

    // Back-pressure: 0x11 held, 0x22 dropped
    ifa.dout_ready = 1'b0;
    send_a(8'h11, 7, 0);
    chk("t3_first",  32'(ifa.dout),       32'h11);
    send_a(8'h22, 7, 0);
    chk("t3_hold",   32'(ifa.dout),       32'h11);
    chk("t3_valid",  32'(ifa.dout_valid), 32'h1);
    chk("t3_ovr",    32'(ifa.overrun),    32'h1);
    chk("t3_cnt0",   32'(ifa.bit_cnt),    32'd0);
    ifa.dout_ready = 1'b1;
    idle_a();
    chk("t3_drain",  32'(ifa.dout_valid), 32'h0);
    ifa.dout_ready = 1'b0;
    idle_a();
    chk("t3_sticky", 32'(ifa.overrun),    32'h1);
    ifa.overrun_clr = 1'b1;
    idle_a();
    ifa.overrun_clr = 1'b0;
    chk("t3_clr",    32'(ifa.overrun),    32'h0);
    send_a(8'h33, 7, 0);
    send_a(8'h44, 7, 1);
    ifa.overrun_clr = 1'b1;
    send_a(8'h44, 0, 0);
    ifa.overrun_clr = 1'b0;
    chk("t3_setwins", 32'(ifa.overrun),   32'h1);
    chk("t3_keep33",  32'(ifa.dout),      32'h33);

    // Drain and complete in the same cycle
    ifa.overrun_clr = 1'b1;
    idle_a();
    ifa.overrun_clr = 1'b0;
    chk("t4_clr",    32'(ifa.overrun),    32'h0);
    ifa.dout_ready = 1'b1;
    idle_a();
    ifa.dout_ready = 1'b0;
    send_a(8'h11, 7, 0);
    send_a(8'h22, 7, 1);
    chk("t4_pre",    32'(ifa.dout),       32'h11);
    chk("t4_prev",   32'(ifa.dout_valid), 32'h1);
    ifa.dout_ready = 1'b1;
    send_a(8'h22, 0, 0);
    chk("t4_dout",   32'(ifa.dout),       32'h22);
    chk("t4_valid",  32'(ifa.dout_valid), 32'h1);
    chk("t4_novr",   32'(ifa.overrun),    32'h0);
    idle_a();
    chk("t4_drain",  32'(ifa.dout_valid), 32'h0);

    // Junk bits then sync with the first bit of 0xC3
    send_a(8'hE0, 7, 5);
    chk("t5_junk",   32'(ifa.bit_cnt),    32'd3);
    ifa.sync = 1'b1;
    send_a(8'hC3, 7, 7);
    ifa.sync = 1'b0;
    chk("t5_cnt1",   32'(ifa.bit_cnt),    32'd1);
    send_a(8'hC3, 6, 3);
    chk("t5_early",  32'(ifa.dout_valid), 32'h0);
    send_a(8'hC3, 2, 0);
    chk("t5_dout",   32'(ifa.dout),       32'hC3);
    chk("t5_valid",  32'(ifa.dout_valid), 32'h1);
    idle_a();

    // Asynchronous reset mid-word with a word held
    ifa.dout_ready = 1'b0;
    send_a(8'hFF, 7, 0);
    send_a(8'h5A, 7, 3);
    chk("t6_prev",   32'(ifa.dout_valid), 32'h1);
    ifa.din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_dout",   32'(ifa.dout),       32'h0);
    chk("t6_valid",  32'(ifa.dout_valid), 32'h0);
    chk("t6_cnt",    32'(ifa.bit_cnt),    32'h0);
    chk("t6_ovr",    32'(ifa.overrun),    32'h0);
    cyc();
    rst_n = 1'b1;
    ifa.dout_ready = 1'b1;
    cyc();
    send_a(8'h5A, 7, 0);
    chk("t6_word",   32'(ifa.dout),       32'h5A);
    chk("t6_wvalid", 32'(ifa.dout_valid), 32'h1);
    idle_a();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
